// File: rtl/ctrl_pkg.sv
// Shared definitions for the gen2 control FSM: state encoding, opcode values,
// and the bit positions of the one-hot bus, register and ALU selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_F1   = 4'd1,
    ST_F2   = 4'd2,
    ST_DEC  = 4'd3,
    ST_EX   = 4'd4,
    ST_MEM  = 4'd5,
    ST_WB   = 4'd6,
    ST_HALT = 4'd7,
    ST_TRAP = 4'd8
  } state_e;

  // Opcodes are kept 32 bits wide so they compare directly against the
  // zero-extended opcode field, whatever OP_W is configured to.
  localparam logic [31:0] OP_NOP  = 32'd0;
  localparam logic [31:0] OP_LDAC = 32'd1;
  localparam logic [31:0] OP_STAC = 32'd2;
  localparam logic [31:0] OP_MVAC = 32'd3;
  localparam logic [31:0] OP_MOVR = 32'd4;
  localparam logic [31:0] OP_ADD  = 32'd5;
  localparam logic [31:0] OP_SUB  = 32'd6;
  localparam logic [31:0] OP_AND  = 32'd7;
  localparam logic [31:0] OP_OR   = 32'd8;
  localparam logic [31:0] OP_JMP  = 32'd9;
  localparam logic [31:0] OP_JZ   = 32'd10;
  localparam logic [31:0] OP_LDI  = 32'd11;
  localparam logic [31:0] OP_HALT = 32'd12;

  localparam int BUS_PC  = 0;
  localparam int BUS_DR  = 1;
  localparam int BUS_IMM = 2;
  localparam int BUS_AC  = 3;
  localparam int BUS_REG = 4;

  localparam int REG_AR = 0;
  localparam int REG_IR = 1;
  localparam int REG_DR = 2;
  localparam int REG_AC = 3;

  // First register index that MVAC may target; below it are architectural regs.
  localparam int REG_FIRST_GP = 4;

  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_AND = 2;
  localparam int ALU_OR  = 3;

  // True for every opcode this generation implements.
  function automatic logic isDefinedOp(input logic [31:0] op);
    return op <= OP_HALT;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decoder: turns the current FSM state plus the instruction
// register (and the handshake/flag inputs) into the datapath control vectors.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int IR_W   = 32,
  parameter int OP_W   = 8,
  parameter int NREG   = 9,
  parameter int RIDX_W = 4,
  parameter int NBUS   = 8,
  parameter int NALU   = 8
) (
  input  state_e            state_i,
  input  logic [IR_W-1:0]   ir_i,
  input  logic              z_i,
  input  logic              memReady_i,
  output logic              memReq_o,
  output logic              pcInc_o,
  output logic              pcLoad_o,
  output logic              finish_o,
  output logic              dataRamWe_o,
  output logic              illegal_o,
  output logic [NALU-1:0]   aluSel_o,
  output logic [NBUS-1:0]   busSel_o,
  output logic [NREG-1:0]   regSel_o
);

  logic [31:0] opcode;
  logic [31:0] rdIdx;
  logic        unusedIrBits;

  assign opcode = 32'(ir_i[OP_W-1:0]);
  assign rdIdx  = 32'(ir_i[OP_W +: RIDX_W]);

  // The rs field and any high IR bits are consumed by the datapath, not here.
  assign unusedIrBits = ^ir_i;

  // Decode state and opcode into strobes and one-hot selects; every select
  // carries at most one set bit because each branch writes a single shift.
  always_comb begin
    memReq_o    = 1'b0;
    pcInc_o     = 1'b0;
    pcLoad_o    = 1'b0;
    finish_o    = 1'b0;
    dataRamWe_o = 1'b0;
    illegal_o   = 1'b0;
    aluSel_o    = '0;
    busSel_o    = '0;
    regSel_o    = '0;
    case (state_i)
      ST_F1: begin
        busSel_o = NBUS'(1) << BUS_PC;
        regSel_o = NREG'(1) << REG_AR;
      end
      ST_F2: begin
        memReq_o = 1'b1;
        if (memReady_i) begin
          regSel_o = NREG'(1) << REG_IR;
          pcInc_o  = 1'b1;
        end
      end
      ST_EX: begin
        case (opcode)
          OP_ADD: begin
            aluSel_o = NALU'(1) << ALU_ADD;
            regSel_o = NREG'(1) << REG_AC;
          end
          OP_SUB: begin
            aluSel_o = NALU'(1) << ALU_SUB;
            regSel_o = NREG'(1) << REG_AC;
          end
          OP_AND: begin
            aluSel_o = NALU'(1) << ALU_AND;
            regSel_o = NREG'(1) << REG_AC;
          end
          OP_OR: begin
            aluSel_o = NALU'(1) << ALU_OR;
            regSel_o = NREG'(1) << REG_AC;
          end
          OP_MOVR: begin
            busSel_o = NBUS'(1) << BUS_REG;
            regSel_o = NREG'(1) << REG_AC;
          end
          OP_MVAC: begin
            busSel_o = NBUS'(1) << BUS_AC;
            if (rdIdx >= 32'(REG_FIRST_GP) && rdIdx < 32'(NREG)) begin
              regSel_o = NREG'(1) << rdIdx;
            end
          end
          OP_LDI: begin
            busSel_o = NBUS'(1) << BUS_IMM;
            regSel_o = NREG'(1) << REG_AC;
          end
          OP_JMP: begin
            busSel_o = NBUS'(1) << BUS_IMM;
            pcLoad_o = 1'b1;
          end
          OP_JZ: begin
            if (z_i) begin
              busSel_o = NBUS'(1) << BUS_IMM;
              pcLoad_o = 1'b1;
            end
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        memReq_o = 1'b1;
        if (opcode == OP_STAC) begin
          busSel_o    = NBUS'(1) << BUS_AC;
          dataRamWe_o = 1'b1;
        end else if (memReady_i) begin
          regSel_o = NREG'(1) << REG_DR;
        end
      end
      ST_WB: begin
        busSel_o = NBUS'(1) << BUS_DR;
        regSel_o = NREG'(1) << REG_AC;
      end
      ST_HALT: begin
        finish_o = 1'b1;
      end
      ST_TRAP: begin
        finish_o  = 1'b1;
        illegal_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm_gen2.sv
// Multi-cycle processor control FSM (gen2) with a RAM ready/wait handshake
// and configurable widths. Define CTRL_ILLEGAL_TRAP_EN to add the illegal
// output and trap undefined opcodes; otherwise they execute as NOP.
module ctrl_fsm_gen2
  import ctrl_pkg::*;
#(
  parameter int IR_W   = 32,
  parameter int OP_W   = 8,
  parameter int NREG   = 9,
  parameter int RIDX_W = 4,
  parameter int NBUS   = 8,
  parameter int NALU   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             z,
  input  logic [IR_W-1:0]  IR,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             finish,
  output logic             data_ram_we,
  output logic             inst_ram_we,
  output logic [NALU-1:0]  alu_sel,
  output logic [NBUS-1:0]  bus_sel,
  output logic [NREG-1:0]  reg_sel
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,output logic            illegal
`endif
);

  state_e state_q;
  state_e state_d;

  logic [31:0]     opcode;
  logic            decMemReq;
  logic            decPcInc;
  logic            decPcLoad;
  logic            decFinish;
  logic            decDataRamWe;
  logic            decIllegal;
  logic [NALU-1:0] decAluSel;
  logic [NBUS-1:0] decBusSel;
  logic [NREG-1:0] decRegSel;

  assign opcode = 32'(IR[OP_W-1:0]);

  // State register with synchronous reset back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; enable is only consulted at instruction boundaries so
  // an instruction already under way always runs to completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_F1;
      ST_F1:   state_d = ST_F2;
      ST_F2:   if (mem_ready) state_d = ST_DEC;
      ST_DEC: begin
        if (opcode == OP_HALT) begin
          state_d = ST_HALT;
        end else if (opcode == OP_LDAC || opcode == OP_STAC) begin
          state_d = ST_MEM;
`ifdef CTRL_ILLEGAL_TRAP_EN
        end else if (!isDefinedOp(opcode)) begin
          state_d = ST_TRAP;
`endif
        end else begin
          state_d = ST_EX;
        end
      end
      ST_EX:   state_d = enable ? ST_F1 : ST_IDLE;
      ST_MEM: begin
        if (mem_ready) begin
          if (opcode == OP_LDAC) begin
            state_d = ST_WB;
          end else begin
            state_d = enable ? ST_F1 : ST_IDLE;
          end
        end
      end
      ST_WB:   state_d = enable ? ST_F1 : ST_IDLE;
      ST_HALT: state_d = ST_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ST_TRAP: state_d = ST_TRAP;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  ctrl_decode #(
    .IR_W   (IR_W),
    .OP_W   (OP_W),
    .NREG   (NREG),
    .RIDX_W (RIDX_W),
    .NBUS   (NBUS),
    .NALU   (NALU)
  ) u_decode (
    .state_i     (state_q),
    .ir_i        (IR),
    .z_i         (z),
    .memReady_i  (mem_ready),
    .memReq_o    (decMemReq),
    .pcInc_o     (decPcInc),
    .pcLoad_o    (decPcLoad),
    .finish_o    (decFinish),
    .dataRamWe_o (decDataRamWe),
    .illegal_o   (decIllegal),
    .aluSel_o    (decAluSel),
    .busSel_o    (decBusSel),
    .regSel_o    (decRegSel)
  );

  // Output stage: a sampled reset forces every output low in that same
  // cycle, so a pending RAM request is withdrawn immediately.
  always_comb begin
    mem_req     = decMemReq;
    pc_inc      = decPcInc;
    pc_load     = decPcLoad;
    finish      = decFinish;
    data_ram_we = decDataRamWe;
    alu_sel     = decAluSel;
    bus_sel     = decBusSel;
    reg_sel     = decRegSel;
    if (reset) begin
      mem_req     = 1'b0;
      pc_inc      = 1'b0;
      pc_load     = 1'b0;
      finish      = 1'b0;
      data_ram_we = 1'b0;
      alu_sel     = '0;
      bus_sel     = '0;
      reg_sel     = '0;
    end
  end

  // Instruction RAM is never written by this generation.
  assign inst_ram_we = 1'b0;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal = decIllegal & ~reset;
`else
  logic unusedIllegal;
  assign unusedIllegal = decIllegal;
`endif

endmodule
